// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared types and encodings for the multi-cycle RV32I main
//               control FSM. Includes the state enum, the RV32I opcode
//               constants, the datapath mux/ALU select encodings, and the
//               packed control word produced by the state decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    // Main FSM states. The encoding is explicit so that trace tools can use
    // the state_o values directly. Encodings 13..15 are unreachable.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    // Supported RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // result mux select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // ALU operation class handed to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Raw per-state control word, before mem_ready gating and reset forcing
    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
    } ctrl_t;

endpackage : mc_ctrl_pkg
`default_nettype wire

// File: rtl/mc_ctrl_outputs.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_outputs
// Description : Purely combinational state-to-control-word decoder for the
//               main FSM. The word it produces depends only on the state;
//               the top applies mem_ready gating and reset forcing.
// Ports       : i_state - current FSM state
//               o_ctrl  - raw control word for that state
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl_outputs
    import mc_ctrl_pkg::*;
(
    input  state_t i_state,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.adr_src    = 1'b0;
                o_ctrl.alu_src_a  = SRCA_PC;
                o_ctrl.alu_src_b  = SRCB_FOUR;
                o_ctrl.alu_op     = ALUOP_ADD;
                o_ctrl.result_src = RES_ALU;
                // The top qualifies both of these with mem_ready
                o_ctrl.ir_write   = 1'b1;
                o_ctrl.pc_update  = 1'b1;
            end
            S_DECODE: begin
                // Precompute oldPC + imm so BEQ/JAL find their target in ALUOut
                o_ctrl.alu_src_a  = SRCA_OLDPC;
                o_ctrl.alu_src_b  = SRCB_IMM;
                o_ctrl.alu_op     = ALUOP_ADD;
            end
            S_MEMADR: begin
                o_ctrl.alu_src_a  = SRCA_RS1;
                o_ctrl.alu_src_b  = SRCB_IMM;
                o_ctrl.alu_op     = ALUOP_ADD;
            end
            S_MEMREAD: begin
                o_ctrl.adr_src    = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.result_src = RES_DATA;
                o_ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                o_ctrl.adr_src    = 1'b1;
                o_ctrl.mem_write  = 1'b1;
            end
            S_EXECR: begin
                o_ctrl.alu_src_a  = SRCA_RS1;
                o_ctrl.alu_src_b  = SRCB_RS2;
                o_ctrl.alu_op     = ALUOP_FUNCT;
            end
            S_EXECI: begin
                o_ctrl.alu_src_a  = SRCA_RS1;
                o_ctrl.alu_src_b  = SRCB_IMM;
                o_ctrl.alu_op     = ALUOP_FUNCT;
            end
            S_LUI: begin
                // 0 + U-immediate
                o_ctrl.alu_src_a  = SRCA_ZERO;
                o_ctrl.alu_src_b  = SRCB_IMM;
                o_ctrl.alu_op     = ALUOP_ADD;
            end
            S_ALUWB: begin
                o_ctrl.result_src = RES_ALUOUT;
                o_ctrl.reg_write  = 1'b1;
            end
            S_BEQ: begin
                o_ctrl.alu_src_a  = SRCA_RS1;
                o_ctrl.alu_src_b  = SRCB_RS2;
                o_ctrl.alu_op     = ALUOP_SUB;
                o_ctrl.result_src = RES_ALUOUT;
                o_ctrl.branch     = 1'b1;
            end
            S_JAL: begin
                // PC <- target held in ALUOut while the ALU forms oldPC + 4
                o_ctrl.alu_src_a  = SRCA_OLDPC;
                o_ctrl.alu_src_b  = SRCB_FOUR;
                o_ctrl.alu_op     = ALUOP_ADD;
                o_ctrl.result_src = RES_ALUOUT;
                o_ctrl.pc_update  = 1'b1;
            end
            default: begin
                // ILLEGAL and unreachable encodings: everything stays 0
            end
        endcase
    end

endmodule : mc_ctrl_outputs
`default_nettype wire

// File: rtl/mc_main_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_main_fsm
// Description : Main control FSM of the multi-cycle RV32I core. Sequences
//               fetch / decode / execute / memory / writeback and drives all
//               datapath enables and mux selects.
// Ports       : clk, rst_n          - clock, async active-low reset
//               opcode              - instr[6:0] from instruction register
//               mem_ready           - memory completes access this cycle
//               pc_write            - unconditional part of the PC load
//               pc_update, branch   - PC load controls
//               adr_src, mem_write  - memory address select / write strobe
//               ir_write            - IR and oldPC load
//               result_src, alu_src_a, alu_src_b, alu_op - datapath selects
//               reg_write           - register file write enable
//               illegal_instr       - sticky illegal-opcode flag
//               state_o             - current state for trace
// Revision    : 1.0 - initial release
// ============================================================================
module mc_main_fsm
    import mc_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_update,
    output logic       branch,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       illegal_instr,
    output logic [3:0] state_o
);

    state_t r_state;
    state_t w_next_state;
    logic   r_illegal;
    ctrl_t  w_ctrl;
    logic   w_in_fetch;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:    w_next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                // Every legal opcode has [1:0]=11, so compressed/garbage
                // encodings fall through to ILLEGAL here.
                case (opcode)
                    OP_LOAD,
                    OP_STORE:  w_next_state = S_MEMADR;
                    OP_R:      w_next_state = S_EXECR;
                    OP_I:      w_next_state = S_EXECI;
                    OP_BRANCH: w_next_state = S_BEQ;
                    OP_JAL:    w_next_state = S_JAL;
                    OP_LUI:    w_next_state = S_LUI;
                    default:   w_next_state = S_ILLEGAL;
                endcase
            end
            // opcode[5] separates store (0100011) from load (0000011)
            S_MEMADR:   w_next_state = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    w_next_state = S_ALUWB;
            S_EXECI:    w_next_state = S_ALUWB;
            S_LUI:      w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BEQ:      w_next_state = S_FETCH;
            S_JAL:      w_next_state = S_ALUWB;
            S_ILLEGAL:  w_next_state = S_ILLEGAL;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // State register and sticky illegal flag. The flag is set on entry to
    // ILLEGAL so it rises together with the state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RESET_STATE;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state == S_ILLEGAL) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control word decode
    // ------------------------------------------------------------------
    mc_ctrl_outputs u_outputs (
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

    assign w_in_fetch = (r_state == S_FETCH);

    // Write enables are qualified with rst_n so that no write can be seen
    // while reset is held, even though FETCH itself would assert them on
    // mem_ready. Selects pass through and show their FETCH values in reset.
    assign ir_write   = rst_n & w_ctrl.ir_write & mem_ready;
    assign pc_update  = rst_n & w_ctrl.pc_update & (mem_ready | ~w_in_fetch);
    assign branch     = rst_n & w_ctrl.branch;
    assign mem_write  = rst_n & w_ctrl.mem_write;
    assign reg_write  = rst_n & w_ctrl.reg_write;

    // The datapath ORs in (branch & zero); this is the unconditional term.
    assign pc_write   = pc_update;

    assign adr_src    = w_ctrl.adr_src;
    assign result_src = w_ctrl.result_src;
    assign alu_src_a  = w_ctrl.alu_src_a;
    assign alu_src_b  = w_ctrl.alu_src_b;
    assign alu_op     = w_ctrl.alu_op;

    assign illegal_instr = r_illegal;
    assign state_o       = r_state;

endmodule : mc_main_fsm
`default_nettype wire

// File: tb/tb_mc_main_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_main_fsm
// Description : Self-checking bench for mc_main_fsm. The stimulus process
//               drives opcode/mem_ready/rst_n and queues the expected
//               per-cycle observation; a monitor pops and compares on the
//               falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_main_fsm;
    import mc_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write;
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] op;
        logic       reg_write;
        logic       illegal;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_update, branch, adr_src, mem_write, ir_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic       reg_write, illegal_instr;
    logic [3:0] state_o;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    mc_main_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_update     (pc_update),
        .branch        (branch),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .illegal_instr (illegal_instr),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected observation, written out per state from the control table.
    function automatic obs_t expv(input state_t s, input logic mr, input logic in_rst);
        obs_t e;
        e    = '0;
        e.st = s;
        case (s)
            S_FETCH:    begin e.src_b = 2'b10; e.result_src = 2'b10;
                              e.ir_write = mr; e.pc_update = mr; end
            S_DECODE:   begin e.src_a = 2'b01; e.src_b = 2'b01; end
            S_MEMADR:   begin e.src_a = 2'b10; e.src_b = 2'b01; end
            S_MEMREAD:  begin e.adr_src = 1'b1; end
            S_MEMWB:    begin e.result_src = 2'b01; e.reg_write = 1'b1; end
            S_MEMWRITE: begin e.adr_src = 1'b1; e.mem_write = 1'b1; end
            S_EXECR:    begin e.src_a = 2'b10; e.src_b = 2'b00; e.op = 2'b10; end
            S_EXECI:    begin e.src_a = 2'b10; e.src_b = 2'b01; e.op = 2'b10; end
            S_LUI:      begin e.src_a = 2'b11; e.src_b = 2'b01; end
            S_ALUWB:    begin e.result_src = 2'b00; e.reg_write = 1'b1; end
            S_BEQ:      begin e.src_a = 2'b10; e.op = 2'b01; e.branch = 1'b1; end
            S_JAL:      begin e.src_a = 2'b01; e.src_b = 2'b10; e.pc_update = 1'b1; end
            S_ILLEGAL:  begin e.illegal = 1'b1; end
            default:    begin end
        endcase
        e.pc_write = e.pc_update;
        if (in_rst) begin
            e.pc_write  = 1'b0;
            e.pc_update = 1'b0;
            e.branch    = 1'b0;
            e.mem_write = 1'b0;
            e.ir_write  = 1'b0;
            e.reg_write = 1'b0;
            e.illegal   = 1'b0;
        end
        return e;
    endfunction

    // Queue the expectation for the current cycle using present inputs
    task automatic expect_now(input state_t s);
        exp_q.push_back(expv(s, mem_ready, !rst_n));
    endtask

    // One clock: state s is expected during this cycle, mem_ready = mr
    task automatic cyc(input state_t s, input logic mr);
        @(posedge clk);
        #1;
        mem_ready = mr;
        expect_now(s);
    endtask

    // Monitor
    initial begin
        obs_t got;
        obs_t want;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = {state_o, pc_write, pc_update, branch, adr_src, mem_write,
                        ir_write, result_src, alu_src_a, alu_src_b, alu_op,
                        reg_write, illegal_instr};
                checks++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL ctl t=%0t got st=%0d word=%h want st=%0d word=%h",
                             $time, got.st, got, want.st, want);
                end
            end
        end
    end

    // Stimulus
    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        opcode    = 7'b0;
        repeat (2) @(posedge clk);
        // In reset with mem_ready high: FETCH selects, no enables
        #1; mem_ready = 1'b1; expect_now(S_FETCH);
        @(posedge clk); #1; rst_n = 1'b1; mem_ready = 1'b0; expect_now(S_FETCH);

        // lw, with one fetch stall
        opcode = OP_LOAD;
        cyc(S_FETCH, 1'b0);
        cyc(S_FETCH, 1'b1);
        cyc(S_DECODE, 1'b1);
        cyc(S_MEMADR, 1'b1);
        cyc(S_MEMREAD, 1'b1);
        cyc(S_MEMWB, 1'b1);

        // sw, three wait cycles in MEMWRITE
        opcode = OP_STORE;
        cyc(S_FETCH, 1'b1);
        cyc(S_DECODE, 1'b1);
        cyc(S_MEMADR, 1'b1);
        cyc(S_MEMWRITE, 1'b0);
        cyc(S_MEMWRITE, 1'b0);
        cyc(S_MEMWRITE, 1'b0);
        cyc(S_MEMWRITE, 1'b1);

        // add (mem_ready low where it must be ignored)
        opcode = OP_R;
        cyc(S_FETCH, 1'b1);
        cyc(S_DECODE, 1'b0);
        cyc(S_EXECR, 1'b0);
        cyc(S_ALUWB, 1'b0);
        // addi
        opcode = OP_I;
        cyc(S_FETCH, 1'b1);
        cyc(S_DECODE, 1'b1);
        cyc(S_EXECI, 1'b0);
        cyc(S_ALUWB, 1'b1);
        // lui
        opcode = OP_LUI;
        cyc(S_FETCH, 1'b1);
        cyc(S_DECODE, 1'b0);
        cyc(S_LUI, 1'b1);
        cyc(S_ALUWB, 1'b0);
        // beq
        opcode = OP_BRANCH;
        cyc(S_FETCH, 1'b1);
        cyc(S_DECODE, 1'b1);
        cyc(S_BEQ, 1'b0);
        // jal
        opcode = OP_JAL;
        cyc(S_FETCH, 1'b1);
        cyc(S_DECODE, 1'b0);
        cyc(S_JAL, 1'b0);
        cyc(S_ALUWB, 1'b1);

        // sw interrupted by reset while MEMWRITE is stalled
        opcode = OP_STORE;
        cyc(S_FETCH, 1'b1);
        cyc(S_DECODE, 1'b1);
        cyc(S_MEMADR, 1'b0);
        cyc(S_MEMWRITE, 1'b0);
        @(posedge clk); #1; mem_ready = 1'b0; rst_n = 1'b0; expect_now(S_FETCH);
        opcode = 7'b0000000;
        @(posedge clk); #1; mem_ready = 1'b1; expect_now(S_FETCH);
        @(posedge clk); #1; rst_n = 1'b1; mem_ready = 1'b1; expect_now(S_FETCH);

        // opcode 0000000 -> ILLEGAL, held for 20 cycles
        cyc(S_DECODE, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cyc(S_ILLEGAL, i[0]);
        end

        // Only reset clears the flag; then opcode 1110011
        @(posedge clk); #1; rst_n = 1'b0; mem_ready = 1'b0; expect_now(S_FETCH);
        opcode = 7'b1110011;
        @(posedge clk); #1; rst_n = 1'b1; mem_ready = 1'b1; expect_now(S_FETCH);
        cyc(S_DECODE, 1'b1);
        cyc(S_ILLEGAL, 1'b1);
        cyc(S_ILLEGAL, 1'b0);

        // Load opcode with bad low bits is also illegal
        @(posedge clk); #1; rst_n = 1'b0; mem_ready = 1'b0; expect_now(S_FETCH);
        opcode = 7'b0000001;
        @(posedge clk); #1; rst_n = 1'b1; mem_ready = 1'b1; expect_now(S_FETCH);
        cyc(S_DECODE, 1'b0);
        cyc(S_ILLEGAL, 1'b0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mc_main_fsm
`default_nettype wire

// File: doc/mc_main_fsm.md
Name: mc_main_fsm

Overview:
- Main control state machine for the multi-cycle RV32I core.
- Sequences the shared datapath (PC, instruction/data memory port, register file, single ALU, result mux) through fetch, decode, execute, memory and writeback steps.
- Consumes the opcode held in the instruction register and drives every datapath enable and mux select.
- Runs alongside the immediate-format decoder and the ALU decoder. It owns ALU op class, never immediate selection.

Parameters:
- RESET_STATE, S_FETCH, state entered on reset (present for bring-up only; must stay S_FETCH in production)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from instruction register; stable from DECODE onward
- mem_ready  in  1  memory port completes the current access this cycle
- pc_write  out  1  PC register load (= pcUpdate | (branch & zero), formed in datapath; this block drives pcUpdate/branch)
- pc_update  out  1  unconditional PC load
- branch  out  1  conditional PC load qualifier
- adr_src  out  1  memory address: 0=PC, 1=ALU result register
- mem_write  out  1  data memory write strobe
- ir_write  out  1  instruction register and oldPC load
- result_src  out  2  00=ALUOut reg, 01=mem data reg, 10=ALU comb result
- alu_src_a  out  2  00=PC, 01=oldPC, 10=rs1 reg, 11=zero
- alu_src_b  out  2  00=rs2 reg, 01=immExt, 10=const 4
- alu_op  out  2  00=add, 01=sub/compare, 10=funct-decoded
- reg_write  out  1  register file write enable
- illegal_instr  out  1  sticky illegal-opcode flag
- state_o  out  4  current state, debug/trace only

Behaviour:
- Moore machine: all outputs decode from the state register only, except FETCH ir_write/pc_update and MEMWRITE mem_write, which are gated as listed.
- rst_n low: state <= RESET_STATE asynchronously; illegal_instr <= 0; all write enables (pc_update, branch, mem_write, ir_write, reg_write) forced 0 while rst_n low. Selects take their FETCH values.
- Reset mid-instruction abandons it with no partial write after the reset edge. The first cycle after release is FETCH.
- Unlisted outputs are 0 in every state.
- FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10, ir_write=pc_update=mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
- DECODE: a=01, b=01, alu_op=00 (precomputes the branch/jal target into ALUOut). Next state:
  - 0000011 -> MEMADR
  - 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - 0110111 -> LUI
  - anything else, including opcode[1:0]!=11 -> ILLEGAL
- MEMADR: a=10, b=01, alu_op=00. Goes to MEMREAD if opcode[5]=0, else MEMWRITE.
- MEMREAD: adr_src=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: adr_src=1, mem_write=1 every cycle in state. Hold until mem_ready, then FETCH.
- EXECR: a=10, b=00, alu_op=10, then ALUWB.
- EXECI: a=10, b=01, alu_op=10, then ALUWB.
- LUI: a=11, b=01, alu_op=00, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BEQ: a=10, b=00, alu_op=01, result_src=00, branch=1, then FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1, then ALUWB (writes the link address).
- ILLEGAL: illegal_instr set to 1, all enables 0. Terminal; left only via reset.
- Cycle counts per instruction, with zero-wait memory:
  - load 5
  - store 4
  - R/I/LUI 4
  - branch 3
  - jal 4
- Each mem_ready stall adds 1 cycle per low cycle.
- mem_ready is ignored in states that make no access.
- Unreachable state encodings go to FETCH on the next clock.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state_t enum (4-bit)
  - opcode constants OP_LOAD/OP_STORE/OP_R/OP_I/OP_BRANCH/OP_JAL/OP_LUI
  - encodings for result_src, alu_src_a, alu_src_b and alu_op
- One sub-module, mc_ctrl_outputs: a purely combinational state-to-control-word decoder. The top keeps the state register, next-state logic, mem_ready gating, reset forcing and the illegal flag.

Test Plan:
- Reset with rst_n low mid-MEMWRITE, mem_ready=0 -> mem_write drops to 0 immediately (async), state_o=FETCH. After release, FETCH with ir_write=1 on the first mem_ready=1.
- lw, opcode 0000011, mem_ready always 1 -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB. reg_write=1 only in cycle 5 with result_src=01.
- sw, opcode 0100011, mem_ready low for 3 cycles in MEMWRITE -> mem_write=1 for 4 consecutive cycles, then FETCH. reg_write never asserted.
- add then addi then lui -> each takes 4 cycles. alu_op=10 in EXECR/EXECI, a=11/b=01 in LUI, reg_write pulses once per instruction.
- beq (1100011) -> 3 cycles with branch=1 only in BEQ. jal (1101111) -> pc_update=1 in JAL, then ALUWB with reg_write=1.
- opcode 0000000 or 1110011 -> ILLEGAL after DECODE. illegal_instr=1 held for 20 cycles with all enables 0, cleared only by rst_n.
